retrig_driver: RTL and testbench

RETRIG_DRIVER -- requirements
Module: retrig_driver

---
 rtl/retrig_driver.sv | 90 +++++++++
 tb/tb_retrig_driver.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/retrig_driver.sv
// Retrigger driver: emits a burst of any-edge retrigger events at a fixed
// interval to keep a downstream monostable held, with stop, timeout guard and event count.
module retrig_driver #(
  parameter int PERIOD_W = 16,
  parameter int TIMEOUT  = 250
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic [PERIOD_W-1:0] period,
  input  logic [7:0]          burst,
  output logic                retrig,
  output logic                retrig_pulse,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [15:0]         ev_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [PERIOD_W:0] TMO = (PERIOD_W + 1)'(TIMEOUT);

  state_t              state;
  logic [PERIOD_W-1:0] per_q;
  logic [PERIOD_W-1:0] cnt;
  logic [7:0]          left;
  logic                cont;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      per_q        <= '0;
      cnt          <= '0;
      left         <= '0;
      cont         <= 1'b0;
      retrig       <= 1'b0;
      retrig_pulse <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      ev_cnt       <= '0;
    end else begin
      retrig_pulse <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            if (period == '0 || {1'b0, period} >= TMO) begin
              err <= 1'b1;
            end else begin
              // First event is issued on the same edge that accepts start.
              state        <= RUN;
              busy         <= 1'b1;
              per_q        <= period;
              cnt          <= period;
              cont         <= (burst == 8'd0);
              left         <= burst - 8'd1;
              retrig       <= ~retrig;
              retrig_pulse <= 1'b1;
              ev_cnt       <= ev_cnt + 16'd1;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (!cont && left == 8'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (cnt == PERIOD_W'(1)) begin
            cnt          <= per_q;
            retrig       <= ~retrig;
            retrig_pulse <= 1'b1;
            ev_cnt       <= ev_cnt + 16'd1;
            if (!cont) left <= left - 8'd1;
          end else begin
            cnt <= cnt - PERIOD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_retrig_driver.sv
// Directed self-checking bench for retrig_driver; inputs change and outputs
// are sampled on the falling clock edge.
module tb_retrig_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] period = '0;
  logic [7:0]  burst = '0;
  logic        retrig, retrig_pulse, busy, done, err;
  logic [15:0] ev_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  retrig_driver #(.PERIOD_W(16), .TIMEOUT(250)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .period(period), .burst(burst), .retrig(retrig),
    .retrig_pulse(retrig_pulse), .busy(busy), .done(done),
    .err(err), .ev_cnt(ev_cnt)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({retrig, retrig_pulse, busy, done, err, ev_cnt} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got r=%b p=%b b=%b d=%b e=%b ev=%h, want all 0",
               retrig, retrig_pulse, busy, done, err, ev_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({retrig_pulse, done, err, busy} !== 4'd0) begin
      errors++;
      $display("FAIL reset_release_strobes: got p=%b d=%b e=%b b=%b, want 0",
               retrig_pulse, done, err, busy);
    end
  endtask

  // period 10, burst 3: events at +1,+11,+21, done at +22; inputs changed mid-run
  task automatic test_basic();
    logic r0, exp_r;
    r0 = retrig;
    period = 16'd10; burst = 8'd3; start = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 2) begin period = 16'd3; burst = 8'd9; end
      exp_r = r0 ^ (k >= 1) ^ (k >= 11) ^ (k >= 21);
      checks++;
      if (retrig_pulse !== (k == 1 || k == 11 || k == 21) || retrig !== exp_r ||
          done !== (k == 22) || busy !== (k <= 21) || err !== 1'b0) begin
        errors++;
        $display("FAIL basic_cycle%0d: got p=%b r=%b d=%b b=%b e=%b, want p=%b r=%b d=%b b=%b e=0",
                 k, retrig_pulse, retrig, done, busy, err,
                 (k == 1 || k == 11 || k == 21), exp_r, (k == 22), (k <= 21));
      end
    end
    checks++;
    if (ev_cnt !== 16'd3) begin
      errors++;
      $display("FAIL basic_ev_cnt: got %0d want 3", ev_cnt);
    end
  endtask

  task automatic test_timeout();
    logic r0;
    logic [15:0] bad [2];
    bad[0] = 16'd250; bad[1] = 16'd0;
    r0 = retrig;
    for (int i = 0; i < 2; i++) begin
      period = bad[i]; burst = 8'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || retrig_pulse !== 1'b0) begin
        errors++;
        $display("FAIL timeout_err_p%0d: got e=%b b=%b p=%b, want e=1 b=0 p=0",
                 bad[i], err, busy, retrig_pulse);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || busy !== 1'b0 || retrig !== r0 || ev_cnt !== 16'd3) begin
        errors++;
        $display("FAIL timeout_after_p%0d: got e=%b b=%b r=%b ev=%0d, want e=0 b=0 r=%b ev=3",
                 bad[i], err, busy, retrig, ev_cnt, r0);
      end
    end
    // largest legal period: burst of one, done the cycle after the event
    period = 16'd249; burst = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (err !== 1'b0 || retrig_pulse !== 1'b1 || busy !== 1'b1 || retrig !== ~r0) begin
      errors++;
      $display("FAIL period249_event: got e=%b p=%b b=%b r=%b, want e=0 p=1 b=1 r=%b",
               err, retrig_pulse, busy, retrig, ~r0);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || retrig_pulse !== 1'b0 || ev_cnt !== 16'd4) begin
      errors++;
      $display("FAIL period249_done: got d=%b b=%b p=%b ev=%0d, want d=1 b=0 p=0 ev=4",
               done, busy, retrig_pulse, ev_cnt);
    end
  endtask

  // continuous, period 5; stop lands on the 4th event; start while busy ignored
  task automatic test_stop();
    int pulses = 0;
    period = 16'd5; burst = 8'd0; start = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      start = (k == 3);
      stop  = (k == 15);
      if (retrig_pulse) pulses++;
      checks++;
      if (retrig_pulse !== (k == 1 || k == 6 || k == 11) || done !== 1'b0 ||
          err !== 1'b0 || busy !== (k <= 15)) begin
        errors++;
        $display("FAIL stop_cycle%0d: got p=%b d=%b e=%b b=%b, want p=%b d=0 e=0 b=%b",
                 k, retrig_pulse, done, err, busy,
                 (k == 1 || k == 6 || k == 11), (k <= 15));
      end
    end
    checks++;
    if (pulses != 3 || ev_cnt !== 16'd7) begin
      errors++;
      $display("FAIL stop_count: got pulses=%0d ev=%0d, want 3 and 7", pulses, ev_cnt);
    end
    // start with stop in IDLE: ignored, no err even for an illegal period
    period = 16'd0; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL startstop_bad: got e=%b b=%b, want 0 0", err, busy);
    end
    period = 16'd5;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    checks++;
    if (err !== 1'b0 || busy !== 1'b0 || retrig_pulse !== 1'b0 || ev_cnt !== 16'd7) begin
      errors++;
      $display("FAIL startstop_ok: got e=%b b=%b p=%b ev=%0d, want 0 0 0 7",
               err, busy, retrig_pulse, ev_cnt);
    end
  endtask

  task automatic test_period1();
    logic r0;
    r0 = retrig;
    period = 16'd1; burst = 8'd4; start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (retrig_pulse !== (k <= 4) || done !== (k == 5) || busy !== (k <= 4)) begin
        errors++;
        $display("FAIL period1_cycle%0d: got p=%b d=%b b=%b, want p=%b d=%b b=%b",
                 k, retrig_pulse, done, busy, (k <= 4), (k == 5), (k <= 4));
      end
    end
    checks++;
    if (retrig !== r0 || ev_cnt !== 16'd11) begin
      errors++;
      $display("FAIL period1_end: got r=%b ev=%0d, want r=%b ev=11", retrig, ev_cnt, r0);
    end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    period = 16'd4; burst = 8'd5; start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (ev_cnt !== 16'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL resetmid_pre: got ev=%0d b=%b, want 2 1", ev_cnt, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({retrig, retrig_pulse, busy, done, err, ev_cnt} !== 21'd0) begin
      errors++;
      $display("FAIL resetmid_async: got r=%b p=%b b=%b d=%b e=%b ev=%h, want all 0",
               retrig, retrig_pulse, busy, done, err, ev_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if (retrig_pulse !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ev_cnt !== 16'd0) begin
        errors++;
        $display("FAIL resetmid_idle%0d: got p=%b b=%b d=%b ev=%0d, want 0 0 0 0",
                 k, retrig_pulse, busy, done, ev_cnt);
      end
    end
  endtask

  task automatic test_wrap();
    logic r0;
    bit   hit = 1'b0;
    r0 = retrig;
    period = 16'd1; burst = 8'd0; start = 1'b1;
    for (int k = 0; k < 70000 && !hit; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (ev_cnt === 16'hFFFE) begin
        stop = 1'b1;
        hit = 1'b1;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL wrap_preload: ev_cnt never reached FFFE, got %h", ev_cnt);
    end
    @(negedge clk);
    stop = 1'b0;
    checks++;
    if (ev_cnt !== 16'hFFFE || busy !== 1'b0 || retrig !== r0) begin
      errors++;
      $display("FAIL wrap_stopped: got ev=%h b=%b r=%b, want FFFE 0 %b", ev_cnt, busy, retrig, r0);
    end
    period = 16'd2; burst = 8'd2; start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (ev_cnt !== 16'h0000 || done !== 1'b1 || err !== 1'b0 || retrig !== r0) begin
      errors++;
      $display("FAIL wrap_zero: got ev=%h d=%b e=%b r=%b, want 0000 1 0 %b",
               ev_cnt, done, err, retrig, r0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_stop();
    test_period1();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
